// File: rtl/display_pkg.sv
// display_pkg: segment constants, hex decode table and parameter legality check for the scan mux.
package display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {a,b,c,d,e,f,g}, indexed by hex value 0..F
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        return SEG_TABLE[hex];
    endfunction

    function automatic bit params_ok(input int n_digits, input int refresh_div,
                                     input int dead_cycles, input int blink_frames);
        return n_digits >= 1 && n_digits <= 8 && dead_cycles >= 0 &&
               refresh_div >= dead_cycles + 2 && blink_frames >= 1;
    endfunction

endpackage

// File: rtl/display_scan_mux_seg7.sv
// seg7_hex_decoder: combinational hex nibble to active-low 7-segment pattern.
module seg7_hex_decoder
    import display_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(hex);

endmodule

// File: rtl/display_scan_mux.sv
// display_scan_mux: N-digit multiplexed common-anode driver with shadow registers, dead-time and blink.
module display_scan_mux
    import display_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int DEAD_CYCLES  = 64,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] digits_in,
    input  logic [N_DIGITS-1:0]   blank_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   blink_in,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [N_DIGITS-1:0]   an_n,
    output logic                  frame_tick
);

    localparam int DW = $clog2(REFRESH_DIV);
    localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
    localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;

    if (!params_ok(N_DIGITS, REFRESH_DIV, DEAD_CYCLES, BLINK_FRAMES)) begin : g_bad_params
        $error("display_scan_mux: illegal parameter combination");
    end

    logic [DW-1:0]         div_cnt;
    logic [IW-1:0]         idx;
    logic [FW-1:0]         frame_cnt;
    logic                  blink_phase;
    logic [4*N_DIGITS-1:0] digits_sh;
    logic [N_DIGITS-1:0]   blank_sh;
    logic [N_DIGITS-1:0]   dp_sh;
    logic [N_DIGITS-1:0]   blink_sh;
    logic                  div_wrap;
    logic                  idx_wrap;
    logic                  frame_wrap;
    logic                  dark;
    logic [6:0]            cur_seg;

    assign div_wrap   = div_cnt == DW'(REFRESH_DIV - 1);
    assign idx_wrap   = div_wrap && idx == IW'(N_DIGITS - 1);
    assign frame_wrap = idx_wrap && frame_cnt == FW'(BLINK_FRAMES - 1);
    // Dead-time at slot start keeps the previous digit's segments from ghosting
    assign dark       = div_cnt < DW'(DEAD_CYCLES) || blank_sh[idx] || (blink_sh[idx] && blink_phase);

    seg7_hex_decoder u_dec (
        .hex (digits_sh[4*idx +: 4]),
        .seg (cur_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt     <= '0;
            idx         <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            digits_sh   <= '0;
            blank_sh    <= '0;
            dp_sh       <= '0;
            blink_sh    <= '0;
            seg_n       <= SEG_BLANK;
            dp_n        <= 1'b1;
            an_n        <= '1;
            frame_tick  <= 1'b0;
        end else begin
            if (load) begin
                digits_sh <= digits_in;
                blank_sh  <= blank_in;
                dp_sh     <= dp_in;
                blink_sh  <= blink_in;
            end
            div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
            if (div_wrap)
                idx <= idx_wrap ? '0 : idx + 1'b1;
            if (idx_wrap)
                frame_cnt <= frame_wrap ? '0 : frame_cnt + 1'b1;
            if (frame_wrap)
                blink_phase <= ~blink_phase;
            frame_tick <= idx_wrap;
            seg_n      <= dark ? SEG_BLANK : cur_seg;
            dp_n       <= dark | ~dp_sh[idx];
            an_n       <= dark ? '1 : ~(N_DIGITS'(1) << idx);
        end
    end

endmodule

// File: tb/tb_display_scan_mux.sv
// tb_display_scan_mux: randomized bench with an arithmetic reference model for two display_scan_mux configurations.
module tb_display_scan_mux;

    localparam int N = 4, R = 8, D = 2, BF = 2;
    localparam int N1 = 1, R1 = 4, D1 = 1, BF1 = 1;

    logic        clk = 0, rst_n = 1, load = 0;
    logic [15:0] digits_in = '0;
    logic [3:0]  blank_in = '0, dp_in = '0, blink_in = '0;
    logic [6:0]  seg_n, seg1_n;
    logic        dp_n, dp1_n, ft, ft1;
    logic [3:0]  an_n;
    logic [0:0]  an1_n;

    int   total = 0, bad = 0, n = 0;
    logic chk_en = 0;

    logic [15:0] sh_dig;
    logic [3:0]  sh_blank, sh_dp, sh_blink;
    logic [6:0]  e_seg, e_seg1;
    logic        e_dp, e_dp1, e_ft, e_ft1, e_an1;
    logic [3:0]  e_an;
    logic [16:0] m0, m1;
    logic [6:0]  hex_tab [16];
    logic [3:0]  lit_an [4];
    logic [6:0]  lit_seg [4];

    always #5 clk = ~clk;

    display_scan_mux #(.N_DIGITS(N), .REFRESH_DIV(R), .DEAD_CYCLES(D), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in), .blank_in(blank_in),
        .dp_in(dp_in), .blink_in(blink_in), .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n), .frame_tick(ft)
    );

    display_scan_mux #(.N_DIGITS(N1), .REFRESH_DIV(R1), .DEAD_CYCLES(D1), .BLINK_FRAMES(BF1)) dut1 (
        .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in[3:0]), .blank_in(blank_in[0]),
        .dp_in(dp_in[0]), .blink_in(blink_in[0]), .seg_n(seg1_n), .dp_n(dp1_n), .an_n(an1_n), .frame_tick(ft1)
    );

    // k = clock edges since reset release before the edge being predicted
    function automatic logic [16:0] model(int nd, int r, int d, int bf, int k);
        int div, ix, ph;
        logic dk;
        logic [7:0] an;
        div = k % r;
        ix  = (k / r) % nd;
        ph  = (k / (r * nd) / bf) % 2;
        dk  = div < d || sh_blank[ix] || (sh_blink[ix] && ph == 1);
        an  = dk ? 8'hFF : ~(8'd1 << ix);
        return {(k % (r * nd)) == r * nd - 1, dk | ~sh_dp[ix], dk ? 7'h7F : hex_tab[sh_dig[4*ix +: 4]], an};
    endfunction

    always_comb m0 = model(N, R, D, BF, n);
    always_comb m1 = model(N1, R1, D1, BF1, n);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n <= 0;
            sh_dig <= '0; sh_blank <= '0; sh_dp <= '0; sh_blink <= '0;
            e_seg <= 7'h7F; e_dp <= 1; e_an <= 4'hF; e_ft <= 0;
            e_seg1 <= 7'h7F; e_dp1 <= 1; e_an1 <= 1; e_ft1 <= 0;
        end else begin
            e_ft <= m0[16]; e_dp <= m0[15]; e_seg <= m0[14:8]; e_an <= m0[3:0];
            e_ft1 <= m1[16]; e_dp1 <= m1[15]; e_seg1 <= m1[14:8]; e_an1 <= m1[0];
            if (load) begin
                sh_dig <= digits_in; sh_blank <= blank_in; sh_dp <= dp_in; sh_blink <= blink_in;
            end
            n <= n + 1;
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("seg_n", seg_n, e_seg);
            chk("dp_n", dp_n, e_dp);
            chk("an_n", an_n, e_an);
            chk("frame_tick", ft, e_ft);
            chk("an_onehot0", $onehot0(~an_n), 1);
            if (n > 0 && (n - 1) % R < D)
                chk("dead_an", an_n, 4'hF);
            chk("n1_seg_n", seg1_n, e_seg1);
            chk("n1_dp_n", dp1_n, e_dp1);
            chk("n1_an_n", an1_n, e_an1);
            chk("n1_frame_tick", ft1, e_ft1);
        end
    end

    task automatic wait_pos(int s, int d);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (n > 0 && (n - 1) % R == d && ((n - 1) / R) % N == s)
                return;
        end
        total++;
        bad++;
        $display("FAIL wait_pos: got timeout want slot %0d offset %0d", s, d);
    endtask

    task automatic pulse_load();
        load = 1;
        @(negedge clk);
        load = 0;
    endtask

    initial begin
        int cnt, cnt1, vis0, vis1;
        hex_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
                    7'b0100000, 7'b0001111, 7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
                    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        lit_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        lit_seg = '{7'b0111000, 7'b0001000, 7'b0010010, 7'b1001111};
        #1 rst_n = 0;
        #1 chk_en = 1;
        repeat (3) @(negedge clk);
        chk("rst_seg", seg_n, 7'h7F);
        chk("rst_an", an_n, 4'hF);
        chk("rst_dp", dp_n, 1);
        rst_n = 1;
        @(negedge clk); chk("rel_c1_an", an_n, 4'hF);
        @(negedge clk); chk("rel_c2_an", an_n, 4'hF);
        @(negedge clk); chk("rel_c3_an", an_n, 4'b1110); chk("rel_c3_seg", seg_n, 7'b0000001);

        digits_in = 16'h12AF;
        pulse_load();
        for (int s = 0; s < 4; s++) begin
            wait_pos(s, 4);
            chk("scan_an", an_n, lit_an[s]);
            chk("scan_seg", seg_n, lit_seg[s]);
        end
        cnt = 0; cnt1 = 0;
        repeat (64) begin
            @(negedge clk);
            cnt += int'(ft);
            cnt1 += int'(ft1);
        end
        chk("ft_per_64", cnt, 2);
        chk("n1_ft_per_64", cnt1, 16);

        blank_in = 4'b0100; dp_in = 4'b0001;
        pulse_load();
        wait_pos(2, 5); chk("blank_an", an_n, 4'hF); chk("blank_seg", seg_n, 7'h7F);
        wait_pos(0, 5); chk("dp0_dp", dp_n, 0); chk("dp0_an", an_n, 4'b1110);
        wait_pos(1, 5); chk("dp1_dp", dp_n, 1);

        blank_in = 0; dp_in = 0; blink_in = 4'b0001;
        pulse_load();
        vis0 = 0; vis1 = 0;
        for (int f = 0; f < 4; f++) begin
            wait_pos(0, 4); vis0 += int'(an_n == 4'b1110);
            wait_pos(1, 4); vis1 += int'(an_n == 4'b1101);
        end
        chk("blink_vis0", vis0, 2);
        chk("blink_vis1", vis1, 4);

        blink_in = 0;
        pulse_load();
        digits_in = 16'h3456;
        wait_pos(1, 3); chk("noload_seg", seg_n, 7'b0001000);
        pulse_load();
        chk("midslot_old_seg", seg_n, 7'b0001000);
        @(negedge clk);
        chk("midslot_new_seg", seg_n, 7'b0100100);
        chk("midslot_new_an", an_n, 4'b1101);

        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            load = $urandom_range(0, 7) == 0;
            if (load) begin
                digits_in = 16'($urandom);
                blank_in  = $urandom_range(0, 3) == 0 ? 4'($urandom) : 4'h0;
                dp_in     = 4'($urandom);
                blink_in  = 4'($urandom);
            end
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 0;
                #1 chk("async_rst_an", an_n, 4'hF);
                chk("async_rst_seg", seg_n, 7'h7F);
                chk("async_rst_ft", ft, 0);
                repeat ($urandom_range(1, 3)) @(negedge clk);
                rst_n = 1;
            end
        end
        load = 0;
        repeat (3) @(negedge clk);
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
